// File: rtl/pipe_stage_ctrl.sv
// Two-entry skid-buffered pipeline stage with flush and optional stall/bubble counters.
// Define PIPE_STAGE_CTRL_PERF_EN to build the performance counters; otherwise they read 0.
module pipe_stage_ctrl #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      bubble_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic             in_fire, out_fire;

    // Handshakes use the registered flags, so in_ready never sees out_ready combinationally.
    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_d = ST_BUSY;
                    main_d  = in_data;
                end
            end
            ST_BUSY: begin
                if (in_fire && out_fire) begin
                    main_d = in_data;
                end else if (in_fire) begin
                    state_d = ST_FULL;
                    skid_d  = in_data;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_fire) begin
                    state_d = ST_BUSY;
                    main_d  = skid_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        // Flush drops the held payloads by state alone; the data registers keep their contents.
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end

        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_FULL);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_q      <= RESET_VAL;
            skid_q      <= RESET_VAL;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;
    assign out_data  = main_q;

`ifdef PIPE_STAGE_CTRL_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    // Both counters stick at all-ones rather than wrapping.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (out_valid_q && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (!out_valid_q && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q  <= 32'd0;
            bubble_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`else
    assign stall_cnt  = 32'd0;
    assign bubble_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Self-checking bench for pipe_stage_ctrl: queue-based reference model plus directed scenarios.
module tb_pipe_stage_ctrl;

    localparam int          W  = 32;
    localparam logic [W-1:0] RV = 32'hDEAD_BEEF;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         flush;
    logic [31:0]  stall_cnt;
    logic [31:0]  bubble_cnt;

    int total = 0;
    int bad   = 0;

    pipe_stage_ctrl #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flush     (flush),
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the stage is a FIFO of depth two; the head register keeps its last value.
    logic [W-1:0] mq[$];
    logic [W-1:0] m_head;
    longint       m_stall, m_bubble;
    bit           model_live = 1'b0;

    function automatic logic [31:0] exp_cnt(input longint v);
`ifdef PIPE_STAGE_CTRL_PERF_EN
        return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
`else
        return 32'd0 + 32'(v & 0);
`endif
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (model_live) begin
                check("cmp_out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
                check("cmp_in_ready", {31'd0, in_ready}, {31'd0, mq.size() < 2});
                check("cmp_out_data", out_data, m_head);
                check("cmp_stall_cnt", stall_cnt, exp_cnt(m_stall));
                check("cmp_bubble_cnt", bubble_cnt, exp_cnt(m_bubble));
            end
            @(posedge clk);
            if (rst) begin
                mq.delete();
                m_head     = RV;
                m_stall    = 0;
                m_bubble   = 0;
                model_live = 1'b1;
            end else if (model_live) begin
                automatic bit ov = mq.size() > 0;
                automatic bit ir = mq.size() < 2;
                if (ov && !out_ready) m_stall++;
                if (!ov) m_bubble++;
                if (flush) begin
                    mq.delete();
                end else begin
                    if (ov && out_ready) void'(mq.pop_front());
                    if (in_valid && ir) mq.push_back(in_data);
                    if (mq.size() > 0) m_head = mq[0];
                end
            end
        end
    end

    // Apply one cycle of inputs; returns #1 after the edge that consumed them.
    task automatic step(input bit iv, input logic [W-1:0] d, input bit ordy,
                        input bit fl = 1'b0, input bit r = 1'b0);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        in_valid = 0; in_data = '0; out_ready = 0; flush = 0; rst = 1;

        // Reset
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_data", out_data, RV);
        check("rst_stall", stall_cnt, 32'd0);

        // Pass-through
        step(1, 32'h11, 1);
        check("pt_data_11", out_data, 32'h11);
        check("pt_ready_1", {31'd0, in_ready}, 32'd1);
        step(1, 32'h22, 1);
        check("pt_data_22", out_data, 32'h22);
        check("pt_ready_2", {31'd0, in_ready}, 32'd1);
        step(1, 32'h33, 1);
        check("pt_data_33", out_data, 32'h33);
        check("pt_ready_3", {31'd0, in_ready}, 32'd1);
        step(0, 0, 1);
        check("pt_drained", {31'd0, out_valid}, 32'd0);
        check("pt_data_kept", out_data, 32'h33);

        // Backpressure
        step(1, 32'hA1, 0);
        step(1, 32'hA2, 0);
        check("bp_full_ready", {31'd0, in_ready}, 32'd0);
        check("bp_head_a1", out_data, 32'hA1);
        step(1, 32'hA3, 0);
        check("bp_hold_head", out_data, 32'hA1);
        step(1, 32'hA3, 1);
        check("bp_head_a2", out_data, 32'hA2);
        step(1, 32'hA3, 1);
        check("bp_head_a3", out_data, 32'hA3);
        check("bp_valid_a3", {31'd0, out_valid}, 32'd1);
        step(0, 0, 1);
        check("bp_empty", {31'd0, out_valid}, 32'd0);

        // Flush while full, with an input offered in the flush cycle
        step(1, 32'hB1, 0);
        step(1, 32'hB2, 0);
        step(1, 32'hB3, 0, 1);
        check("fl_out_valid", {31'd0, out_valid}, 32'd0);
        check("fl_in_ready", {31'd0, in_ready}, 32'd1);
        check("fl_main_kept", out_data, 32'hB1);
        step(0, 0, 1);
        step(0, 0, 1);
        check("fl_no_b3", {31'd0, out_valid}, 32'd0);

        // Flush in BUSY together with an output fire and an input fire
        step(1, 32'hC0, 0);
        step(1, 32'hC1, 1, 1);
        check("fl_busy_empty", {31'd0, out_valid}, 32'd0);
        check("fl_busy_data", out_data, 32'hC0);

        // Counters: 1 bubble, 5 stalls, 1 fire, 2 bubbles
        step(0, 0, 0, 0, 1);
        step(1, 32'hC5, 0);
        repeat (5) step(0, 0, 0);
        step(0, 0, 1);
        step(0, 0, 1);
        step(0, 0, 1);
`ifdef PIPE_STAGE_CTRL_PERF_EN
        check("cnt_stall_5", stall_cnt, 32'd5);
        check("cnt_bubble_3", bubble_cnt, 32'd3);
`else
        check("cnt_stall_0", stall_cnt, 32'd0);
        check("cnt_bubble_0", bubble_cnt, 32'd0);
`endif

        // Mixed traffic
        for (int i = 0; i < 40; i++) begin
            step((i % 3) != 2, 32'h4000 + i, (i % 5) < 3, (i == 17) || (i == 31));
        end

        // Reset mid-operation from FULL; reset wins over flush and input
        step(1, 32'hD1, 0);
        step(1, 32'hD2, 0);
        check("mr_full", {31'd0, in_ready}, 32'd0);
        step(1, 32'hD3, 0, 1, 1);
        check("mr_out_valid", {31'd0, out_valid}, 32'd0);
        check("mr_out_data", out_data, RV);
        check("mr_in_ready", {31'd0, in_ready}, 32'd1);
        check("mr_stall", stall_cnt, 32'd0);
        check("mr_bubble", bubble_cnt, 32'd0);
        step(0, 0, 1);
        step(0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
